hilo_muldiv: RTL and testbench
==============================

# hilo_muldiv

Parametrised HI/LO unit for the execute stage. Holds the architectural HI/LO register pair and adds the multi-cycle MULT/MULTU/DIV/DIVU engines that write it. Also performs single-cycle MTHI/MTLO writes, including a simultaneous write of both registers. Provides a valid/ready issue handshake, a busy/done indication for pipeline stall control, and a cancel input that lets exceptions squash an in-flight operation.

## Interface
- `DATA_W`, 32: register and operand width; must be even and ≥ 8.
- `MUL_STAGES`, 2: multiplier latency in cycles (≥ 1); pipeline registers inside the multiply path.
- `clk` in 1: clock, all state updates on rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `op_valid` in 1: operation presented this cycle.
- `op_code` in 3: MTLO=0, MTHI=1, MTHL=2 (hi←src_a, lo←src_b), MULT=3, MULTU=4, DIV=5, DIVU=6; 7 is reserved and accepted as a no-op.
- `src_a` in DATA_W: rs operand, or the dividend/multiplicand.
- `src_b` in DATA_W: rt operand, or the divisor/multiplier.
- `op_ready` out 1: high only in IDLE. An operation is accepted when `op_valid & op_ready & ~cancel`.
- `cancel` in 1: squashes the in-flight multiply/divide and blocks acceptance in the same cycle.
- `busy` out 1: high in any non-IDLE state.
- `done` out 1: high for exactly the cycle whose closing edge completes a multiply/divide.
- `hi` out DATA_W: registered HI value.
- `lo` out DATA_W: registered LO value.

## Operation
- States: IDLE, MUL, DIV, FIX.
- IDLE, with MTLO/MTHI/MTHL accepted:
  - The write happens at the accepting edge.
  - The state stays IDLE.
  - `done` stays low.
- IDLE, with MULT/MULTU accepted:
  - The unit enters MUL and loads `cnt = MUL_STAGES-1`.
  - MUL decrements `cnt`. With `cnt==0` and no cancel, `done=1` and the edge writes `{hi,lo} = product`, then returns to IDLE.
  - The full 2·DATA_W-bit product is used. MULT is signed×signed; MULTU is unsigned.
- IDLE, with DIV/DIVU accepted and `src_b != 0`:
  - The unit latches operand magnitudes and sign flags, then enters DIV with `cnt = DATA_W-1`.
  - DIV runs one restoring radix-2 step per cycle: shift-subtract, producing one quotient bit each step.
  - When `cnt==0` it moves to FIX.
  - FIX applies sign correction: the quotient is negated if the signs differ, and the remainder takes the sign of the dividend (truncation toward zero). FIX asserts `done` and writes `lo = quotient`, `hi = remainder`, then returns to IDLE.
- DIV/DIVU with `src_b == 0`:
  - The unit goes directly to FIX and asserts `done` there.
  - The HI/LO write is suppressed; the registers keep their values.
- Overflow (DIV of the most-negative value by −1): `lo` = the most-negative value, `hi` = 0. No trap is raised.
- `cancel` in MUL/DIV/FIX:
  - The next state is IDLE.
  - No write occurs and `done` is forced low.
  - Cancel in IDLE has no effect on HI/LO and also blocks an MT* write that cycle.
- `op_valid` while busy is ignored. The issuing stage must hold the operation until it is accepted.
- Reset (asynchronous, any time, including mid-operation):
  - `hi`, `lo` ← 0; state ← IDLE.
  - `cnt` and divider datapath ← 0.
  - Outputs: `op_ready=1`, `busy=0`, `done=0`.

## Timing
- MT*: accepted at edge e; the new `hi`/`lo` are visible after edge e. `op_ready` stays high, so back-to-back MT* writes are allowed every cycle.
- MULT/MULTU: accepted at e; results visible after e+MUL_STAGES. `busy` is high for cycles e+1…e+MUL_STAGES.
- DIV/DIVU (nonzero divisor): accepted at e; results visible after e+DATA_W+1. For DATA_W=32 this is edge e+33.
- Divide by zero: `done` is high in cycle e+1; the unit is IDLE after e+1.
- New issue: the earliest acceptance is in the cycle after the `done` cycle. There is no overlap between operations.
- `hi`/`lo` are never forwarded combinationally from the engine. The reader sees the old value until the write edge.

## Structure
- Package `hilo_pkg`:
  - `op_code` enum/localparams.
  - state enum.
  - Helper function `clog2` for the `cnt` width, which is `clog2(DATA_W)`.
- Sub-module `hilo_div`: the iterative signed/unsigned divider.
  - Inputs: start, signed, operands, cancel.
  - Outputs: quotient, remainder, valid.
  - The top level owns the FSM, the multiplier pipeline, and the HI/LO registers.
- The multiplier is inline: a `*` operator followed by MUL_STAGES registers.

## Test plan
- Reset, then MTHL with a=0x11111111, b=0x22222222 → after one edge, hi=0x11111111, lo=0x22222222. Assert resetn mid-cycle → both clear immediately.
- MULT a=0xFFFFFFFD (−3), b=5 → at e+2, hi=0xFFFFFFFF, lo=0xFFFFFFF1, and `done` is high for one cycle. MULTU with the same operands → hi=0x00000004, lo=0xFFFFFFF1.
- DIVU 100/7 → at e+33, lo=14, hi=2. DIV −7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000/−1 → lo=0x80000000, hi=0.
- DIV 42/0 with hi/lo preloaded to 0xA5A5A5A5/0x5A5A5A5A → `done` at e+1, registers unchanged, `op_ready` high at e+2.
- DIVU issued, then `cancel` pulsed at cycle e+10 → no write, IDLE at e+11. A new MTLO issued during the busy cycles is not accepted until `op_ready` returns.
- DIVU issued, then resetn asserted at e+20 → hi=lo=0 and `busy`=0 immediately. After reset is released, a MULTU 3×4 gives lo=12, hi=0.

Source files
------------

// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: opcodes, FSM states
// and the counter-width helper.
package hilo_pkg;

    typedef enum logic [2:0] {
        OP_MTLO  = 3'd0,
        OP_MTHI  = 3'd1,
        OP_MTHL  = 3'd2,
        OP_MULT  = 3'd3,
        OP_MULTU = 3'd4,
        OP_DIV   = 3'd5,
        OP_DIVU  = 3'd6,
        OP_RSVD  = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_FIX
    } state_e;

    function automatic int clog2(input int value);
        int result;
        int rest;
        result = 0;
        rest   = value - 1;
        while (rest > 0) begin
            result++;
            rest = rest >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/hilo_if.sv
// Issue/handshake bundle between the execute stage and the HI/LO unit.
interface hilo_if #(parameter int DATA_W = 32);
    logic              op_valid;
    logic [2:0]        op_code;
    logic [DATA_W-1:0] src_a;
    logic [DATA_W-1:0] src_b;
    logic              cancel;
    logic              op_ready;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;

    modport master (
        output op_valid, op_code, src_a, src_b, cancel,
        input  op_ready, busy, done, hi, lo
    );

    modport slave (
        input  op_valid, op_code, src_a, src_b, cancel,
        output op_ready, busy, done, hi, lo
    );
endinterface

// File: rtl/hilo_div.sv
// Iterative restoring radix-2 divider on operand magnitudes; the sign fix-up
// is applied combinationally on the outputs.
module hilo_div
    import hilo_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              i_start,
    input  logic              i_signed,
    input  logic [DATA_W-1:0] i_dividend,
    input  logic [DATA_W-1:0] i_divisor,
    input  logic              i_cancel,
    output logic [DATA_W-1:0] o_quotient,
    output logic [DATA_W-1:0] o_remainder,
    output logic              o_valid
);
    localparam int CNT_W = clog2(DATA_W);

    logic [DATA_W-1:0] r_rem;
    logic [DATA_W-1:0] r_quo;
    logic [DATA_W-1:0] r_dvs;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_run;
    logic              r_valid;
    logic              r_neg_q;
    logic              r_neg_r;

    logic              w_a_neg;
    logic              w_b_neg;
    logic [DATA_W-1:0] w_a_mag;
    logic [DATA_W-1:0] w_b_mag;
    logic [DATA_W:0]   w_shift;
    logic [DATA_W:0]   w_diff;

    assign w_a_neg = i_signed & i_dividend[DATA_W-1];
    assign w_b_neg = i_signed & i_divisor[DATA_W-1];
    assign w_a_mag = w_a_neg ? -i_dividend : i_dividend;
    assign w_b_mag = w_b_neg ? -i_divisor : i_divisor;

    // Partial remainder stays below the divisor, so bit DATA_W of the difference is its sign.
    assign w_shift = {r_rem, r_quo[DATA_W-1]};
    assign w_diff  = w_shift - {1'b0, r_dvs};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rem   <= '0;
            r_quo   <= '0;
            r_dvs   <= '0;
            r_cnt   <= '0;
            r_run   <= 1'b0;
            r_valid <= 1'b0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else if (i_cancel) begin
            r_run   <= 1'b0;
            r_valid <= 1'b0;
        end else if (i_start) begin
            r_rem   <= '0;
            r_quo   <= w_a_mag;
            r_dvs   <= w_b_mag;
            r_cnt   <= CNT_W'(DATA_W - 1);
            r_run   <= 1'b1;
            r_valid <= 1'b0;
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
        end else if (r_run) begin
            if (!w_diff[DATA_W]) begin
                r_rem <= w_diff[DATA_W-1:0];
                r_quo <= {r_quo[DATA_W-2:0], 1'b1};
            end else begin
                r_rem <= w_shift[DATA_W-1:0];
                r_quo <= {r_quo[DATA_W-2:0], 1'b0};
            end
            r_cnt   <= r_cnt - 1'b1;
            r_run   <= (r_cnt != '0);
            r_valid <= (r_cnt == '0);
        end else begin
            r_valid <= 1'b0;
        end
    end

    assign o_quotient  = r_neg_q ? -r_quo : r_quo;
    assign o_remainder = r_neg_r ? -r_rem : r_rem;
    assign o_valid     = r_valid;

endmodule

// File: rtl/hilo_muldiv.sv
// HI/LO register pair with single-cycle MT* writes, a pipelined multiplier
// and the iterative divider, sequenced by a four-state FSM.
module hilo_muldiv
    import hilo_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int MUL_STAGES = 2
) (
    input logic  clk,
    input logic  resetn,
    hilo_if.slave bus
);
    localparam int CNT_W  = clog2(DATA_W);
    localparam int PROD_W = 2 * DATA_W;

    state_e            r_state;
    state_e            w_state_n;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_n;
    logic [DATA_W-1:0] r_hi;
    logic [DATA_W-1:0] r_lo;
    logic [DATA_W-1:0] w_hi_n;
    logic [DATA_W-1:0] w_lo_n;
    logic              w_done;

    op_e               w_op;
    logic              w_accept;
    logic              w_mul_load;
    logic              w_div_start;
    logic              w_div_zero;
    logic              w_mul_signed;
    logic [PROD_W-1:0] w_a_ext;
    logic [PROD_W-1:0] w_b_ext;
    logic [PROD_W-1:0] w_prod;
    logic [PROD_W-1:0] r_pipe [MUL_STAGES];

    logic [DATA_W-1:0] w_quo;
    logic [DATA_W-1:0] w_rem;
    logic              w_div_valid;

    assign w_op         = op_e'(bus.op_code);
    assign w_accept     = bus.op_valid & (r_state == ST_IDLE) & ~bus.cancel;
    assign w_div_zero   = (bus.src_b == '0);
    assign w_mul_load   = w_accept & ((w_op == OP_MULT) | (w_op == OP_MULTU));
    assign w_div_start  = w_accept & ((w_op == OP_DIV) | (w_op == OP_DIVU)) & ~w_div_zero;
    assign w_mul_signed = (w_op == OP_MULT);

    // Extending to the full product width lets one unsigned multiply serve both signednesses.
    assign w_a_ext = w_mul_signed ? {{DATA_W{bus.src_a[DATA_W-1]}}, bus.src_a} : {{DATA_W{1'b0}}, bus.src_a};
    assign w_b_ext = w_mul_signed ? {{DATA_W{bus.src_b[DATA_W-1]}}, bus.src_b} : {{DATA_W{1'b0}}, bus.src_b};
    assign w_prod  = w_a_ext * w_b_ext;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < MUL_STAGES; i++) r_pipe[i] <= '0;
        end else begin
            if (w_mul_load) r_pipe[0] <= w_prod;
            for (int i = 1; i < MUL_STAGES; i++) r_pipe[i] <= r_pipe[i-1];
        end
    end

    hilo_div #(.DATA_W(DATA_W)) u_div (
        .clk         (clk),
        .resetn      (resetn),
        .i_start     (w_div_start),
        .i_signed    (w_op == OP_DIV),
        .i_dividend  (bus.src_a),
        .i_divisor   (bus.src_b),
        .i_cancel    (bus.cancel),
        .o_quotient  (w_quo),
        .o_remainder (w_rem),
        .o_valid     (w_div_valid)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            r_hi    <= w_hi_n;
            r_lo    <= w_lo_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        w_hi_n    = r_hi;
        w_lo_n    = r_lo;
        w_done    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    case (w_op)
                        OP_MTLO: w_lo_n = bus.src_a;
                        OP_MTHI: w_hi_n = bus.src_a;
                        OP_MTHL: begin
                            w_hi_n = bus.src_a;
                            w_lo_n = bus.src_b;
                        end
                        OP_MULT, OP_MULTU: begin
                            w_state_n = ST_MUL;
                            w_cnt_n   = CNT_W'(MUL_STAGES - 1);
                        end
                        OP_DIV, OP_DIVU: begin
                            if (w_div_zero) begin
                                w_state_n = ST_FIX;
                            end else begin
                                w_state_n = ST_DIV;
                                w_cnt_n   = CNT_W'(DATA_W - 1);
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ST_MUL: begin
                if (bus.cancel) begin
                    w_state_n = ST_IDLE;
                end else if (r_cnt == '0) begin
                    w_done    = 1'b1;
                    w_state_n = ST_IDLE;
                    {w_hi_n, w_lo_n} = r_pipe[MUL_STAGES-1];
                end else begin
                    w_cnt_n = r_cnt - 1'b1;
                end
            end
            ST_DIV: begin
                if (bus.cancel) begin
                    w_state_n = ST_IDLE;
                end else if (r_cnt == '0) begin
                    w_state_n = ST_FIX;
                end else begin
                    w_cnt_n = r_cnt - 1'b1;
                end
            end
            ST_FIX: begin
                w_state_n = ST_IDLE;
                // A divide by zero reaches here without a divider result, so nothing is written.
                if (!bus.cancel) begin
                    w_done = 1'b1;
                    if (w_div_valid) begin
                        w_lo_n = w_quo;
                        w_hi_n = w_rem;
                    end
                end
            end
            default: w_state_n = ST_IDLE;
        endcase
    end

    assign bus.op_ready = (r_state == ST_IDLE);
    assign bus.busy     = (r_state != ST_IDLE);
    assign bus.done     = w_done;
    assign bus.hi       = r_hi;
    assign bus.lo       = r_lo;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Scoreboard bench for hilo_muldiv: directed ops push expected HI/LO, a
// monitor checks them on every done pulse.
module tb_hilo_muldiv;
    import hilo_pkg::*;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        string       name;
    } exp_t;

    logic clk;
    logic resetn;
    int   nAsserts;
    int   nFails;
    exp_t sbQ[$];
    exp_t monExp;

    hilo_if #(.DATA_W(32)) bus ();

    hilo_muldiv #(.DATA_W(32), .MUL_STAGES(2)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nAsserts++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    // Drives at the falling edge and returns just after the accepting rising edge.
    task automatic applyStimulus(input op_e op, input logic [31:0] a, input logic [31:0] b);
        int wait_cnt;
        @(negedge clk);
        bus.op_valid = 1'b1;
        bus.op_code  = op;
        bus.src_a    = a;
        bus.src_b    = b;
        wait_cnt = 0;
        while (!bus.op_ready && wait_cnt < 100) begin
            @(negedge clk);
            wait_cnt++;
        end
        if (wait_cnt >= 100) checkOutput("issue_timeout", 64'(bus.op_ready), 64'd1);
        @(posedge clk);
        #1;
        bus.op_valid = 1'b0;
    endtask

    task automatic waitDone(input int expN, input string nm);
        int  n;
        bit  seen;
        n    = 0;
        seen = 0;
        while (!seen && n < 100) begin
            @(negedge clk);
            n++;
            if (bus.done) seen = 1;
        end
        checkOutput({nm, "_latency"}, 64'(n), 64'(expN));
    endtask

    task automatic runOp(input op_e op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] expHi, input logic [31:0] expLo,
                         input int expN, input string nm);
        exp_t e;
        e.hi   = expHi;
        e.lo   = expLo;
        e.name = nm;
        sbQ.push_back(e);
        applyStimulus(op, a, b);
        checkOutput({nm, "_busy"}, 64'(bus.busy), 64'd1);
        waitDone(expN, nm);
        @(negedge clk);
        checkOutput({nm, "_done_pulse"}, 64'(bus.done), 64'd0);
        checkOutput({nm, "_ready_after"}, 64'(bus.op_ready), 64'd1);
    endtask

    always begin
        @(negedge clk);
        if (resetn && bus.done) begin
            if (sbQ.size() == 0) begin
                nAsserts++;
                nFails++;
                $display("[TB] FAIL unexpected_done: got done=1, required no pending operation");
            end else begin
                monExp = sbQ.pop_front();
                @(posedge clk);
                #1;
                checkOutput({monExp.name, "_hi"}, 64'(bus.hi), 64'(monExp.hi));
                checkOutput({monExp.name, "_lo"}, 64'(bus.lo), 64'(monExp.lo));
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        clk          = 1'b0;
        resetn       = 1'b0;
        nAsserts     = 0;
        nFails       = 0;
        bus.op_valid = 1'b0;
        bus.op_code  = 3'd0;
        bus.src_a    = '0;
        bus.src_b    = '0;
        bus.cancel   = 1'b0;

        repeat (3) @(negedge clk);
        checkOutput("reset_hi", 64'(bus.hi), 64'd0);
        checkOutput("reset_lo", 64'(bus.lo), 64'd0);
        checkOutput("reset_ready", 64'(bus.op_ready), 64'd1);
        checkOutput("reset_busy", 64'(bus.busy), 64'd0);
        checkOutput("reset_done", 64'(bus.done), 64'd0);
        resetn = 1'b1;

        applyStimulus(OP_MTHL, 32'h11111111, 32'h22222222);
        checkOutput("mthl_hi", 64'(bus.hi), 64'h11111111);
        checkOutput("mthl_lo", 64'(bus.lo), 64'h22222222);
        checkOutput("mthl_ready", 64'(bus.op_ready), 64'd1);
        checkOutput("mthl_done", 64'(bus.done), 64'd0);
        applyStimulus(OP_MTLO, 32'h33333333, 32'h0);
        checkOutput("mtlo_lo", 64'(bus.lo), 64'h33333333);
        checkOutput("mtlo_hi_kept", 64'(bus.hi), 64'h11111111);
        applyStimulus(OP_MTHI, 32'h44444444, 32'h0);
        checkOutput("mthi_hi", 64'(bus.hi), 64'h44444444);
        checkOutput("mthi_lo_kept", 64'(bus.lo), 64'h33333333);

        @(negedge clk);
        #2;
        resetn = 1'b0;
        #1;
        checkOutput("async_rst_hi", 64'(bus.hi), 64'd0);
        checkOutput("async_rst_lo", 64'(bus.lo), 64'd0);
        @(negedge clk);
        resetn = 1'b1;

        runOp(OP_MULT,  32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 2, "mult");
        runOp(OP_MULTU, 32'hFFFFFFFD, 32'd5, 32'h00000004, 32'hFFFFFFF1, 2, "multu");
        runOp(OP_DIVU,  32'd100, 32'd7, 32'd2, 32'd14, 33, "divu");
        runOp(OP_DIV,   32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 33, "div_neg");
        runOp(OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 33, "div_ovf");

        applyStimulus(OP_MTHL, 32'hA5A5A5A5, 32'h5A5A5A5A);
        runOp(OP_DIV, 32'd42, 32'd0, 32'hA5A5A5A5, 32'h5A5A5A5A, 1, "div_zero");

        // Cancelled divide, with an MTLO held pending until the unit frees up.
        applyStimulus(OP_DIVU, 32'd100, 32'd7);
        bus.op_valid = 1'b1;
        bus.op_code  = OP_MTLO;
        bus.src_a    = 32'h12345678;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (k == 5) begin
                checkOutput("cancel_busy_mid", 64'(bus.busy), 64'd1);
                checkOutput("cancel_mtlo_blocked", 64'(bus.lo), 64'h5A5A5A5A);
            end
        end
        @(negedge clk);
        bus.cancel = 1'b1;
        @(negedge clk);
        bus.cancel = 1'b0;
        checkOutput("cancel_idle_busy", 64'(bus.busy), 64'd0);
        checkOutput("cancel_idle_ready", 64'(bus.op_ready), 64'd1);
        checkOutput("cancel_hi_kept", 64'(bus.hi), 64'hA5A5A5A5);
        checkOutput("cancel_lo_kept", 64'(bus.lo), 64'h5A5A5A5A);
        @(posedge clk);
        #1;
        bus.op_valid = 1'b0;
        checkOutput("held_mtlo_lo", 64'(bus.lo), 64'h12345678);
        checkOutput("held_mtlo_hi", 64'(bus.hi), 64'hA5A5A5A5);

        applyStimulus(OP_DIVU, 32'd100, 32'd7);
        repeat (20) @(negedge clk);
        #2;
        resetn = 1'b0;
        #1;
        checkOutput("middiv_rst_hi", 64'(bus.hi), 64'd0);
        checkOutput("middiv_rst_lo", 64'(bus.lo), 64'd0);
        checkOutput("middiv_rst_busy", 64'(bus.busy), 64'd0);
        checkOutput("middiv_rst_ready", 64'(bus.op_ready), 64'd1);
        @(negedge clk);
        resetn = 1'b1;

        runOp(OP_MULTU, 32'd3, 32'd4, 32'd0, 32'd12, 2, "multu_post_rst");

        repeat (3) @(negedge clk);
        checkOutput("scoreboard_empty", 64'(sbQ.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule
